// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults for the convolution pipeline (window buffer and convolver_complex).
package conv_pkg;
   localparam int BW        = 16;
   localparam int FRAC_BIT  = 8;
   localparam int KERN_DIM  = 5;
   localparam int KERN_SIZE = KERN_DIM * KERN_DIM;
   localparam int WIDTH     = 28;
   localparam int HEIGHT    = 28;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of storage, asynchronous read-old with write-new at the same address.
module conv_line_buffer #(
   parameter int BW    = conv_pkg::BW,
   parameter int WIDTH = conv_pkg::WIDTH
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(WIDTH)-1:0] addr,
   input  logic [BW-1:0]            din,
   output logic [BW-1:0]            dout
);
   logic [BW-1:0] mem [WIDTH];
   assign dout = mem[addr];
   always_ff @(posedge clk)
      if (we) mem[addr] <= din;
endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: turns a raster pixel stream into flat KxK windows for every fully-interior position.
module conv_window_buffer #(
   parameter int BW       = conv_pkg::BW,
   parameter int KERN_DIM = conv_pkg::KERN_DIM,
   parameter int WIDTH    = conv_pkg::WIDTH,
   parameter int HEIGHT   = conv_pkg::HEIGHT,
   localparam int KERN_SIZE = KERN_DIM * KERN_DIM
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      iValid,
   input  logic [BW-1:0]             iPixel,
   output logic [BW*KERN_SIZE-1:0]   oWindow,
   output logic                      oValid,
   output logic                      oFrame_done
);
   localparam int COL_BW = $clog2(WIDTH);
   localparam int ROW_BW = $clog2(HEIGHT);
   localparam logic [COL_BW-1:0] COL_LAST  = COL_BW'(WIDTH - 1);
   localparam logic [COL_BW-1:0] COL_FIRST = COL_BW'(KERN_DIM - 1);
   localparam logic [ROW_BW-1:0] ROW_LAST  = ROW_BW'(HEIGHT - 1);
   localparam logic [ROW_BW-1:0] ROW_FIRST = ROW_BW'(KERN_DIM - 1);
   if (WIDTH < KERN_DIM || HEIGHT < KERN_DIM) begin : g_bad_size
      $error("conv_window_buffer: WIDTH and HEIGHT must be at least KERN_DIM");
   end
   logic [COL_BW-1:0] col;
   logic [ROW_BW-1:0] row;
   logic [BW-1:0]     lb_out  [KERN_DIM-1];
   logic [BW-1:0]     col_new [KERN_DIM];
   logic [BW-1:0]     win     [KERN_DIM][KERN_DIM];
   logic              col_last, row_last;
   assign col_last = col == COL_LAST;
   assign row_last = row == ROW_LAST;
   assign col_new[KERN_DIM-1] = iPixel;
   // lb[k] holds the row k+1 above the current one, so it feeds window row K-2-k
   for (genvar k = 0; k < KERN_DIM - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
         conv_line_buffer #(.BW(BW), .WIDTH(WIDTH)) u_lb (
            .clk(clk), .we(iValid), .addr(col), .din(iPixel), .dout(lb_out[k])
         );
      end else begin : g_tail
         conv_line_buffer #(.BW(BW), .WIDTH(WIDTH)) u_lb (
            .clk(clk), .we(iValid), .addr(col), .din(lb_out[k-1]), .dout(lb_out[k])
         );
      end
      assign col_new[KERN_DIM-2-k] = lb_out[k];
   end
   for (genvar i = 0; i < KERN_DIM; i++) begin : g_row
      for (genvar j = 0; j < KERN_DIM; j++) begin : g_col
         assign oWindow[BW*(i*KERN_DIM+j) +: BW] = win[i][j];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         col         <= '0;
         row         <= '0;
         oValid      <= 1'b0;
         oFrame_done <= 1'b0;
         for (int i = 0; i < KERN_DIM; i++)
            for (int j = 0; j < KERN_DIM; j++)
               win[i][j] <= '0;
      end else begin
         oValid      <= iValid && row >= ROW_FIRST && col >= COL_FIRST;
         oFrame_done <= iValid && row_last && col_last;
         if (iValid) begin
            col <= col_last ? '0 : col + COL_BW'(1);
            if (col_last) row <= row_last ? '0 : row + ROW_BW'(1);
            for (int i = 0; i < KERN_DIM; i++) begin
               for (int j = 0; j < KERN_DIM - 1; j++)
                  win[i][j] <= win[i][j+1];
               win[i][KERN_DIM-1] <= col_new[i];
            end
         end
      end
   end
endmodule
